// File: rtl/reaction_timer_ctrl_if.sv
// Reaction-timer controller bus: debounced keys, ms tick and counter
// value in; counter control, LEDs and results out.
interface reaction_timer_ctrl_if #(
  parameter int unsigned N_LED = 10
);
  logic             tick;
  logic             key_start;
  logic             key_react;
  logic [15:0]      count_in;
  logic             en_reaction_counter;
  logic             clr_reaction_counter;
  logic [N_LED-1:0] ledr;
  logic [15:0]      reaction_time;
  logic [15:0]      best_time;
  logic             result_valid;
  logic             false_start;

  modport master (
    output tick,
    output key_start,
    output key_react,
    output count_in,
    input  en_reaction_counter,
    input  clr_reaction_counter,
    input  ledr,
    input  reaction_time,
    input  best_time,
    input  result_valid,
    input  false_start
  );

  modport slave (
    input  tick,
    input  key_start,
    input  key_react,
    input  count_in,
    output en_reaction_counter,
    output clr_reaction_counter,
    output ledr,
    output reaction_time,
    output best_time,
    output result_valid,
    output false_start
  );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game sequencer: LED sweep, random hold-off, timed
// reaction window, result capture and best-time tracking.
module reaction_timer_ctrl #(
  parameter int unsigned N_LED       = 10,
  parameter int unsigned ARM_STEP_MS = 100,
  parameter int unsigned RAND_MIN_MS = 1000,
  parameter logic [15:0] RAND_MASK   = 16'h07FF,
  parameter logic [15:0] TIMEOUT_MS  = 16'd9999,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  reaction_timer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_WAIT,
    S_TIME,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [15:0] STEP_LAST = 16'(ARM_STEP_MS - 1);
  localparam logic [4:0]  LIT_FULL  = 5'(N_LED);
  localparam logic [16:0] HOLD_MIN  = 17'(RAND_MIN_MS);
  localparam logic [15:0] ALT16     = 16'hAAAA;
  localparam logic [N_LED-1:0] ALL_ON = '1;
  localparam logic [N_LED-1:0] ALT    = ALT16[N_LED-1:0];

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      step_cnt;
  logic [4:0]       lit;
  logic [16:0]      hold;
  logic [N_LED-1:0] ledr_q;
  logic [15:0]      rt_q;
  logic [15:0]      best_q;
  logic             en_q;
  logic             clr_q;
  logic             rv_q;
  logic             fs_q;

  logic        fb;
  logic [4:0]  lit_nxt;
  logic [15:0] result;
  logic        restart;
  logic        fault;
  logic        finish;

  function automatic logic [N_LED-1:0] lit_mask(input logic [4:0] n);
    logic [N_LED-1:0] m;
    m = ALL_ON;
    return ~(m << n);
  endfunction

  assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lit_nxt = lit + 5'd1;

  // A key press in the same cycle as timeout still counts as a reaction.
  assign result = bus.key_react ? bus.count_in : TIMEOUT_MS;
  assign finish = bus.key_react | (bus.count_in >= TIMEOUT_MS);

  assign restart = bus.key_start &
                   (state inside {S_IDLE, S_DONE, S_FAULT});
  assign fault   = bus.key_react &
                   (state inside {S_SWEEP, S_WAIT});

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      lfsr     <= LFSR_SEED;
      step_cnt <= '0;
      lit      <= '0;
      hold     <= '0;
      ledr_q   <= '0;
      rt_q     <= '0;
      best_q   <= 16'hFFFF;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      rv_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], fb};
      clr_q <= 1'b0;
      rv_q  <= 1'b0;
      unique case (1'b1)
        restart: begin
          state    <= S_SWEEP;
          clr_q    <= 1'b1;
          step_cnt <= '0;
          lit      <= '0;
          ledr_q   <= '0;
          fs_q     <= 1'b0;
        end
        fault: begin
          state  <= S_FAULT;
          fs_q   <= 1'b1;
          ledr_q <= ALT;
        end
        default: begin
          unique case (state)
            S_SWEEP: begin
              if (bus.tick) begin
                if (step_cnt == STEP_LAST) begin
                  step_cnt <= '0;
                  lit      <= lit_nxt;
                  ledr_q   <= lit_mask(lit_nxt);
                  if (lit_nxt == LIT_FULL) begin
                    state  <= S_WAIT;
                    ledr_q <= ALL_ON;
                    hold   <= HOLD_MIN +
                              {1'b0, lfsr & RAND_MASK};
                  end
                end else begin
                  step_cnt <= step_cnt + 16'd1;
                end
              end
            end
            S_WAIT: begin
              if (bus.tick) begin
                hold <= hold - 17'd1;
                if (hold == 17'd1) begin
                  state  <= S_TIME;
                  en_q   <= 1'b1;
                  ledr_q <= '0;
                end
              end
            end
            S_TIME: begin
              if (finish) begin
                state  <= S_DONE;
                en_q   <= 1'b0;
                rt_q   <= result;
                rv_q   <= 1'b1;
                ledr_q <= result[N_LED-1:0];
                if (result < best_q) best_q <= result;
              end
            end
            S_IDLE, S_DONE, S_FAULT: ;
            default: state <= S_IDLE;
          endcase
        end
      endcase
    end
  end

  assign bus.en_reaction_counter  = en_q;
  assign bus.clr_reaction_counter = clr_q;
  assign bus.ledr                 = ledr_q;
  assign bus.reaction_time        = rt_q;
  assign bus.best_time            = best_q;
  assign bus.result_valid         = rv_q;
  assign bus.false_start          = fs_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: directed game runs plus random play,
// checked every cycle against a behavioural model of the game.
module tb_reaction_timer_ctrl;

  localparam int N    = 10;
  localparam int ARM  = 2;
  localparam int RMIN = 4;
  localparam logic [15:0] MASK = 16'd3;
  localparam logic [15:0] TO   = 16'd50;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reaction_timer_ctrl_if #(.N_LED(N)) bus ();

  reaction_timer_ctrl #(
    .N_LED(N),
    .ARM_STEP_MS(ARM),
    .RAND_MIN_MS(RMIN),
    .RAND_MASK(MASK),
    .TIMEOUT_MS(TO),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum {M_IDLE, M_SWEEP, M_WAIT, M_TIME, M_DONE, M_FAULT} mst_t;

  // Model of game state; expected outputs follow from these.
  mst_t        ms = M_IDLE;
  int          ticks = 0;
  int          left = 0;
  int          pre_ticks = 0;
  int          ctr = 0;
  logic [15:0] lf = SEED;
  logic [15:0] rt = '0;
  logic [15:0] best = 16'hFFFF;
  logic        en_e = 1'b0;
  logic        clr_e = 1'b0;
  logic        rv_e = 1'b0;
  logic        fs_e = 1'b0;

  int nerr = 0;
  int nchk = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) begin
    logic [15:0] l0;
    logic [15:0] res;
    // external reaction counter fed by the expected enable/clear
    if (clr_e) ctr = 0;
    else if (en_e && bus.tick) ctr = ctr + 1;
    l0 = lf;
    lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    clr_e = 1'b0;
    rv_e  = 1'b0;
    if (rst) begin
      ms = M_IDLE; lf = SEED; rt = '0; best = 16'hFFFF;
      ticks = 0; left = 0;
    end else if (bus.key_start &&
                 (ms == M_IDLE || ms == M_DONE || ms == M_FAULT)) begin
      ms = M_SWEEP; clr_e = 1'b1; ticks = 0; pre_ticks = 0;
    end else if (bus.key_react && (ms == M_SWEEP || ms == M_WAIT)) begin
      ms = M_FAULT;
    end else begin
      case (ms)
        M_SWEEP: if (bus.tick) begin
          ticks++; pre_ticks++;
          if (ticks == N * ARM) begin
            ms = M_WAIT;
            left = RMIN + int'(l0 & MASK);
          end
        end
        M_WAIT: if (bus.tick) begin
          left--; pre_ticks++;
          if (left == 0) ms = M_TIME;
        end
        M_TIME: if (bus.key_react || bus.count_in >= TO) begin
          res = bus.key_react ? bus.count_in : TO;
          rt = res; rv_e = 1'b1; ms = M_DONE;
          if (res < best) best = res;
        end
        default: ;
      endcase
    end
    en_e = (ms == M_TIME);
    fs_e = (ms == M_FAULT);
  end

  function automatic logic [N-1:0] exp_ledr();
    logic [N-1:0] r;
    r = '0;
    case (ms)
      M_SWEEP: for (int i = 0; i < N; i++) r[i] = (i < ticks / ARM);
      M_WAIT:  r = '1;
      M_DONE:  r = rt[N-1:0];
      M_FAULT: for (int i = 0; i < N; i++) r[i] = ((i % 2) == 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ledr", 16'(bus.ledr), 16'(exp_ledr()));
    chk("en", 16'(bus.en_reaction_counter), 16'(en_e));
    chk("clr", 16'(bus.clr_reaction_counter), 16'(clr_e));
    chk("reaction_time", bus.reaction_time, rt);
    chk("best_time", bus.best_time, best);
    chk("result_valid", 16'(bus.result_valid), 16'(rv_e));
    chk("false_start", 16'(bus.false_start), 16'(fs_e));
  endtask

  // One cycle: compare at negedge, then drive next inputs.
  task automatic drive(input logic ks, input logic kr,
                       input int rat = -1, input int ov = -1);
    logic k;
    @(negedge clk);
    if (chk_on) compare_all();
    #1;
    k = kr | (rat >= 0 && ctr == rat);
    bus.tick      = ($urandom_range(0, 2) == 0);
    bus.key_start = ks;
    bus.key_react = k;
    bus.count_in  = (k && ov >= 0) ? 16'(ov) : 16'(ctr);
  endtask

  task automatic wait_state(input mst_t s, input int budget);
    int n;
    n = 0;
    while (ms != s && n < budget) begin
      drive(1'b0, 1'b0);
      n++;
    end
    if (ms != s) begin
      nchk++; nerr++;
      $display("FAIL wait_%s: got %s required %s", s.name(), ms.name(),
               s.name());
    end
  endtask

  task automatic react_at(input int target, input int ov);
    int n;
    n = 0;
    do begin
      drive(1'b0, 1'b0, target, ov);
      n++;
    end while (!bus.key_react && n < 2000);
    if (!bus.key_react) begin
      nchk++; nerr++;
      $display("FAIL react_at_%0d: counter never got there", target);
    end
    drive(1'b0, 1'b0);
  endtask

  initial begin
    bus.tick = 1'b0; bus.key_start = 1'b0;
    bus.key_react = 1'b0; bus.count_in = '0;
    rst = 1'b1;
    drive(1'b0, 1'b0);
    chk_on = 1'b1;
    drive(1'b0, 1'b0);
    chk("rst_ledr", 16'(bus.ledr), 16'h0000);
    chk("rst_en", 16'(bus.en_reaction_counter), 16'h0000);
    chk("rst_best", bus.best_time, 16'hFFFF);
    chk("rst_rt", bus.reaction_time, 16'h0000);
    chk("rst_fs", 16'(bus.false_start), 16'h0000);
    rst = 1'b0;

    // run 1: sweep, hold-off, react at 37
    drive(1'b1, 1'b0);
    wait_state(M_WAIT, 500);
    chk("wait_ledr", 16'(bus.ledr), 16'h03FF);
    wait_state(M_TIME, 500);
    chk("time_en", 16'(bus.en_reaction_counter), 16'h0001);
    chk("arm_ticks_ok", 16'(pre_ticks >= 24 && pre_ticks <= 27), 16'h1);
    react_at(37, -1);
    chk("r1_rt", bus.reaction_time, 16'd37);
    chk("r1_rv", 16'(bus.result_valid), 16'h0001);
    chk("r1_best", bus.best_time, 16'd37);
    chk("r1_en", 16'(bus.en_reaction_counter), 16'h0000);

    // run 2: press lands with counter showing 52, past timeout
    drive(1'b1, 1'b0);
    wait_state(M_TIME, 500);
    react_at(20, 52);
    chk("r2_rt", bus.reaction_time, 16'd52);
    chk("r2_best", bus.best_time, 16'd37);

    // run 3: faster result becomes best
    drive(1'b1, 1'b0);
    wait_state(M_TIME, 500);
    react_at(12, -1);
    chk("r3_rt", bus.reaction_time, 16'd12);
    chk("r3_best", bus.best_time, 16'd12);

    // false start during hold-off
    drive(1'b1, 1'b0);
    wait_state(M_WAIT, 500);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk("fault_fs", 16'(bus.false_start), 16'h0001);
    chk("fault_ledr", 16'(bus.ledr), 16'h02AA);
    chk("fault_rv", 16'(bus.result_valid), 16'h0000);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("restart_clr", 16'(bus.clr_reaction_counter), 16'h0001);
    chk("restart_fs", 16'(bus.false_start), 16'h0000);

    // no reaction: timeout saturates at 50
    wait_state(M_TIME, 500);
    wait_state(M_DONE, 3000);
    chk("to_rt", bus.reaction_time, 16'd50);
    chk("to_rv", 16'(bus.result_valid), 16'h0001);
    chk("to_best", bus.best_time, 16'd12);

    // reset in the middle of the reaction window
    drive(1'b1, 1'b0);
    wait_state(M_TIME, 500);
    repeat (5) drive(1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0);
    chk("mid_rst_en", 16'(bus.en_reaction_counter), 16'h0000);
    chk("mid_rst_best", bus.best_time, 16'hFFFF);
    chk("mid_rst_rt", bus.reaction_time, 16'h0000);
    rst = 1'b0;

    // random play
    for (int i = 0; i < 6000; i++) begin
      logic ks;
      logic kr;
      ks  = ($urandom_range(0, 15) == 0);
      kr  = (ms == M_TIME) ? ($urandom_range(0, 19) == 0)
                           : ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 1999) == 0);
      drive(ks, kr);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
